// File: rtl/sdram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sdram_port_arbiter
// Purpose  : Converts level-style RAM strobes of NCH clients into the toggle
//            req/ack handshake of one SDRAM port. Each client has a one-deep
//            pending slot with a sticky overflow flag. Grants are round-robin.
// Revision : 1.0  initial release
// ============================================================================
module sdram_port_arbiter #(
  parameter int NCH = 2,
  parameter int AW  = 16
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic [NCH-1:0]    ch_cs,
  input  logic [NCH-1:0]    ch_oe,
  input  logic [NCH-1:0]    ch_we,
  input  logic [NCH*AW-1:0] ch_addr,
  input  logic [NCH*8-1:0]  ch_d,
  output logic [NCH*8-1:0]  ch_q,
  output logic [NCH-1:0]    ch_done,
  output logic [NCH-1:0]    ch_busy,
  output logic [NCH-1:0]    ch_ovf,
  output logic              mem_req,
  input  logic              mem_ack,
  output logic [AW-1:0]     mem_a,
  output logic              mem_we,
  output logic [1:0]        mem_ds,
  output logic [15:0]       mem_d,
  input  logic [15:0]       mem_q
);

  localparam int LW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t            state;
  logic [LW-1:0]     last;      // most recently granted channel
  logic [LW-1:0]     gnt;       // channel owning the in-flight access

  logic [NCH-1:0]    old_rd;
  logic [NCH-1:0]    old_wr;
  logic [NCH*AW-1:0] old_a;

  logic [NCH-1:0]    pend_valid;
  logic [NCH-1:0]    pend_we;
  logic [AW-1:0]     pend_addr [NCH];
  logic [7:0]        pend_d    [NCH];

  logic [NCH-1:0]    ev;
  logic [NCH-1:0]    ev_we;

  logic              sel_found;
  logic [LW-1:0]     sel;
  logic [AW-1:0]     sel_addr;
  logic              sel_we;
  logic [7:0]        sel_d;
  logic              grant;
  logic [NCH-1:0]    grant_oh;

  // Detect new requests: read/write rising edges, or a read held while the address moves.
  // A write edge wins over a coincident read condition.
  always_comb begin
    ev    = '0;
    ev_we = '0;
    for (int i = 0; i < NCH; i++) begin
      ev_we[i] = ch_cs[i] & ch_we[i] & ~old_wr[i];
      ev[i]    = ev_we[i] |
                 (ch_cs[i] & ch_oe[i] &
                  (~old_rd[i] | (ch_addr[i*AW +: AW] != old_a[i*AW +: AW])));
    end
  end

  // Registered copies of the strobes and addresses for edge/change detection.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      old_rd <= '0;
      old_wr <= '0;
      old_a  <= '0;
    end else begin
      old_rd <= ch_cs & ch_oe;
      old_wr <= ch_cs & ch_we;
      old_a  <= ch_addr;
    end
  end

  // Round-robin pick: first valid slot above 'last', else wrap to the lowest valid slot.
  always_comb begin
    sel_found = 1'b0;
    sel       = '0;
    for (int i = 0; i < NCH; i++) begin
      if (!sel_found && pend_valid[i] && (LW'(i) > last)) begin
        sel_found = 1'b1;
        sel       = LW'(i);
      end
    end
    for (int i = 0; i < NCH; i++) begin
      if (!sel_found && pend_valid[i]) begin
        sel_found = 1'b1;
        sel       = LW'(i);
      end
    end
    grant    = (state == ST_IDLE) && sel_found;
    sel_addr = '0;
    sel_we   = 1'b0;
    sel_d    = '0;
    grant_oh = '0;
    for (int i = 0; i < NCH; i++) begin
      if (sel == LW'(i)) begin
        sel_addr = pend_addr[i];
        sel_we   = pend_we[i];
        sel_d    = pend_d[i];
      end
      grant_oh[i] = grant && (sel == LW'(i));
    end
  end

  // Pending slots: latest event wins; overwriting an ungranted slot sets the sticky flag.
  // An event landing on the grant cycle refills the slot without flagging overflow.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      pend_valid <= '0;
      pend_we    <= '0;
      ch_ovf     <= '0;
      for (int i = 0; i < NCH; i++) begin
        pend_addr[i] <= '0;
        pend_d[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (ev[i]) begin
          pend_valid[i] <= 1'b1;
          pend_we[i]    <= ev_we[i];
          pend_addr[i]  <= ch_addr[i*AW +: AW];
          pend_d[i]     <= ch_d[i*8 +: 8];
          if (pend_valid[i] && !grant_oh[i]) begin
            ch_ovf[i] <= 1'b1;
          end
        end else if (grant_oh[i]) begin
          pend_valid[i] <= 1'b0;
        end
      end
    end
  end

  // Access sequencer: issue the granted slot with a req toggle, then wait for ack equality.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      last    <= LW'(NCH - 1);
      gnt     <= '0;
      mem_req <= 1'b0;
      mem_a   <= '0;
      mem_we  <= 1'b0;
      mem_ds  <= 2'b00;
      mem_d   <= '0;
      ch_q    <= '0;
      ch_done <= '0;
    end else begin
      ch_done <= '0;
      case (state)
        ST_IDLE: begin
          if (grant) begin
            mem_a   <= sel_addr;
            mem_we  <= sel_we;
            mem_ds  <= sel_we ? (sel_addr[0] ? 2'b10 : 2'b01) : 2'b11;
            mem_d   <= {sel_d, sel_d};
            mem_req <= ~mem_req;
            last    <= sel;
            gnt     <= sel;
            state   <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (mem_ack == mem_req) begin
            for (int i = 0; i < NCH; i++) begin
              if (gnt == LW'(i)) begin
                if (!mem_we) begin
                  ch_q[i*8 +: 8] <= mem_a[0] ? mem_q[15:8] : mem_q[7:0];
                end
                ch_done[i] <= 1'b1;
              end
            end
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // A channel is busy while its slot is full or it owns the in-flight access.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      ch_busy[i] = pend_valid[i] | ((state == ST_WAIT) && (gnt == LW'(i)));
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sdram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdram_port_arbiter
// Purpose  : Self-checking bench for sdram_port_arbiter (NCH=3) with a
//            toggle-handshake memory responder and a byte-level memory model.
// Revision : 1.0  initial release
// ============================================================================
module tb_sdram_port_arbiter;

  localparam int NCH = 3;
  localparam int AW  = 16;

  logic              clk_sys = 1'b0;
  logic              reset;
  logic [NCH-1:0]    ch_cs, ch_oe, ch_we;
  logic [NCH*AW-1:0] ch_addr;
  logic [NCH*8-1:0]  ch_d, ch_q;
  logic [NCH-1:0]    ch_done, ch_busy, ch_ovf;
  logic              mem_req, mem_ack, mem_we;
  logic [AW-1:0]     mem_a;
  logic [1:0]        mem_ds;
  logic [15:0]       mem_d, mem_q;

  sdram_port_arbiter #(.NCH(NCH), .AW(AW)) dut (
    .clk_sys(clk_sys), .reset(reset),
    .ch_cs(ch_cs), .ch_oe(ch_oe), .ch_we(ch_we),
    .ch_addr(ch_addr), .ch_d(ch_d), .ch_q(ch_q),
    .ch_done(ch_done), .ch_busy(ch_busy), .ch_ovf(ch_ovf),
    .mem_req(mem_req), .mem_ack(mem_ack), .mem_a(mem_a),
    .mem_we(mem_we), .mem_ds(mem_ds), .mem_d(mem_d), .mem_q(mem_q)
  );

  always #5 clk_sys = ~clk_sys;

  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // ---------------- memory responder ----------------
  typedef struct {
    logic [AW-1:0] a;
    logic          we;
    logic [1:0]    ds;
    logic [15:0]   d;
    int            cyc;
  } acc_t;

  acc_t        log_q[$];
  int          ackc_q[$];
  logic [15:0] ram [16];
  logic [3:0]  rw;
  int          ack_delay = 4;
  bit          rbusy = 1'b0;
  int          rcnt = 0;

  initial begin
    mem_ack = 1'b0;
    mem_q   = '0;
    forever begin
      acc_t e;
      @(negedge clk_sys);
      if (reset) begin
        if (rbusy) ackc_q.push_back(-1);
        rbusy   = 1'b0;
        mem_ack = 1'b0;
      end else begin
        if (!rbusy && (mem_req != mem_ack)) begin
          e.a = mem_a; e.we = mem_we; e.ds = mem_ds; e.d = mem_d; e.cyc = cyc;
          log_q.push_back(e);
          rbusy = 1'b1;
          rcnt  = ack_delay;
        end
        if (rbusy) begin
          if (rcnt <= 1) begin
            rw = mem_a[4:1];
            if (mem_we) begin
              if (mem_ds[0]) ram[rw][7:0]  = mem_d[7:0];
              if (mem_ds[1]) ram[rw][15:8] = mem_d[15:8];
            end else begin
              mem_q = ram[rw];
            end
            mem_ack = mem_req;
            rbusy   = 1'b0;
            ackc_q.push_back(cyc);
          end else begin
            rcnt--;
          end
        end
      end
    end
  end

  // ---------------- output monitors ----------------
  int done_cnt [NCH];
  bit busy_watch = 1'b0;
  int busy_gap   = 0;

  initial begin
    forever begin
      @(negedge clk_sys);
      for (int c = 0; c < NCH; c++) if (ch_done[c]) done_cnt[c]++;
      if (busy_watch && !ch_busy[0]) busy_gap++;
    end
  end

  function automatic int total_done();
    int s = 0;
    for (int c = 0; c < NCH; c++) s += done_cnt[c];
    return s;
  endfunction

  // ---------------- reference model ----------------
  logic [7:0]    model_mem [32];
  logic [7:0]    exp_q     [NCH];
  int            model_last = NCH - 1;
  logic          req_we [NCH];
  logic [AW-1:0] req_a  [NCH];
  logic [7:0]    req_d  [NCH];
  int            post_cyc = 0;

  function automatic logic [1:0] exp_ds(input logic we, input logic [AW-1:0] a);
    if (!we) return 2'b11;
    return a[0] ? 2'b10 : 2'b01;
  endfunction

  task automatic set_word(input int w, input logic [15:0] v);
    ram[w]           = v;
    model_mem[2*w]   = v[7:0];
    model_mem[2*w+1] = v[15:8];
  endtask

  task automatic model_reset();
    model_last = NCH - 1;
    for (int c = 0; c < NCH; c++) exp_q[c] = 8'h00;
  endtask

  task automatic do_reset();
    @(negedge clk_sys);
    reset = 1'b1;
    @(negedge clk_sys);
    @(negedge clk_sys);
    reset = 1'b0;
    model_reset();
  endtask

  // one-cycle strobe on every channel in mask, using req_* as the request
  task automatic pulse(input logic [NCH-1:0] mask);
    @(negedge clk_sys);
    for (int c = 0; c < NCH; c++) begin
      if (mask[c]) begin
        ch_cs[c] = 1'b1;
        ch_oe[c] = ~req_we[c];
        ch_we[c] = req_we[c];
        ch_addr[c*AW +: AW] = req_a[c];
        ch_d[c*8 +: 8]      = req_d[c];
      end
    end
    post_cyc = cyc;
    @(negedge clk_sys);
    ch_cs = '0; ch_oe = '0; ch_we = '0;
  endtask

  task automatic wait_done(input int target, input int bound, input string tag);
    int k = 0;
    while (total_done() < target && k < bound) begin
      @(negedge clk_sys);
      k++;
    end
    check(tag, total_done(), target);
  endtask

  task automatic wait_log(input int target, input int bound, input string tag);
    int k = 0;
    while (log_q.size() < target && k < bound) begin
      @(negedge clk_sys);
      k++;
    end
    check(tag, log_q.size(), target);
  endtask

  // post mask in one cycle; expected grant order is a rotation starting after model_last
  task automatic run_round(input logic [NCH-1:0] mask, input string tag);
    int base, nd, c;
    int order[$];
    acc_t e;
    base = log_q.size();
    nd   = total_done();
    for (int k = 1; k <= NCH; k++) begin
      c = (model_last + k) % NCH;
      if (mask[c]) order.push_back(c);
    end
    pulse(mask);
    wait_done(nd + order.size(), 40 * NCH, {tag, "_done"});
    check({tag, "_nacc"}, log_q.size() - base, order.size());
    foreach (order[j]) begin
      c = order[j];
      if (base + j < log_q.size()) begin
        e = log_q[base + j];
        check({tag, "_addr"}, e.a, req_a[c]);
        check({tag, "_we"}, e.we, req_we[c]);
        check({tag, "_ds"}, e.ds, exp_ds(req_we[c], req_a[c]));
        if (req_we[c]) begin
          check({tag, "_d"}, e.d, {req_d[c], req_d[c]});
          model_mem[req_a[c][4:0]] = req_d[c];
        end else begin
          exp_q[c] = model_mem[req_a[c][4:0]];
        end
      end
      model_last = c;
    end
    @(negedge clk_sys);
    for (int k = 0; k < NCH; k++) check({tag, "_q"}, ch_q[k*8 +: 8], exp_q[k]);
  endtask

  // ---------------- stimulus ----------------
  localparam logic [AW-1:0] WALK_A0 = 16'h0040;

  initial begin
    int base, nd;
    logic [AW-1:0] wa [5];
    acc_t e;

    reset = 1'b1;
    ch_cs = '0; ch_oe = '0; ch_we = '0; ch_addr = '0; ch_d = '0;
    for (int w = 0; w < 16; w++) set_word(w, 16'($urandom));
    model_reset();
    repeat (3) @(negedge clk_sys);

    // reset state
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_a", mem_a, 0);
    check("rst_mem_ctl", {mem_we, mem_ds}, 0);
    check("rst_mem_d", mem_d, 0);
    check("rst_ch_q", ch_q, 0);
    check("rst_ch_flags", {ch_done, ch_busy, ch_ovf}, 0);
    reset = 1'b0;

    // single read at odd byte address: upper lane returned
    set_word(4'hA, 16'hABCD);
    ack_delay = 4;
    req_we[0] = 1'b0; req_a[0] = 16'h1235; req_d[0] = 8'h00;
    base = log_q.size();
    run_round(3'b001, "rd");
    check("rd_q_const", ch_q[7:0], 8'hAB);
    check("rd_done_once", done_cnt[0], 1);
    check("rd_req_level", mem_req, 1);
    if (log_q.size() > base) check("rd_latency", log_q[base].cyc - post_cyc, 2);

    // write to even byte: lower lane enable, duplicated data
    req_we[1] = 1'b1; req_a[1] = 16'h2000; req_d[1] = 8'h5A;
    run_round(3'b010, "wr");
    check("wr_mem_we", mem_we, 1);
    check("wr_mem_ds", mem_ds, 2'b01);
    check("wr_mem_d", mem_d, 16'h5A5A);
    check("wr_done_once", done_cnt[1], 1);

    // round-robin from reset: 0,1,2
    do_reset();
    ack_delay = 3;
    for (int c = 0; c < NCH; c++) begin
      req_we[c] = 1'b0; req_a[c] = 16'h0100 + AW'(c * 3); req_d[c] = 8'h00;
    end
    run_round(3'b111, "rr3");

    // ch0 and ch2 post while ch2 is in flight: order 0 then 2
    ack_delay = 8;
    req_a[2] = 16'h0311;
    base = log_q.size();
    nd   = total_done();
    pulse(3'b100);
    wait_log(base + 1, 60, "rr2_grant2");
    req_a[0] = 16'h0402; req_a[2] = 16'h0517;
    pulse(3'b101);
    wait_done(nd + 3, 120, "rr2_done");
    check("rr2_nacc", log_q.size() - base, 3);
    if (log_q.size() >= base + 3) begin
      check("rr2_first", log_q[base+1].a, 16'h0402);
      check("rr2_second", log_q[base+2].a, 16'h0517);
    end
    exp_q[0] = model_mem[5'h02];
    exp_q[2] = model_mem[5'h17];
    model_last = 2;
    @(negedge clk_sys);
    check("rr2_q0", ch_q[7:0], exp_q[0]);
    check("rr2_q2", ch_q[23:16], exp_q[2]);

    // randomized rounds against the byte memory model
    for (int r = 0; r < 30; r++) begin
      ack_delay = $urandom_range(1, 6);
      for (int c = 0; c < NCH; c++) begin
        req_we[c] = 1'($urandom_range(0, 1));
        req_a[c]  = AW'($urandom);
        req_d[c]  = 8'($urandom);
      end
      run_round(NCH'($urandom_range(1, 7)), "rnd");
    end
    check("rnd_no_ovf", ch_ovf, 0);

    // address walk with a slow ack: overwrite flags overflow, latest address wins
    ack_delay = 10;
    for (int i = 0; i < 5; i++) wa[i] = WALK_A0 + AW'(i * 17);
    base = log_q.size();
    nd   = total_done();
    @(negedge clk_sys);
    ch_cs[0] = 1'b1; ch_oe[0] = 1'b1; ch_addr[0 +: AW] = wa[0];
    for (int i = 1; i < 5; i++) begin
      repeat (2) @(negedge clk_sys);
      ch_addr[0 +: AW] = wa[i];
    end
    wait_done(nd + 2, 100, "walk_done");
    ch_cs[0] = 1'b0; ch_oe[0] = 1'b0;
    repeat (4) @(negedge clk_sys);
    check("walk_nacc", log_q.size() - base, 2);
    if (log_q.size() >= base + 2) begin
      check("walk_first", log_q[base].a, wa[0]);
      check("walk_latest", log_q[base+1].a, wa[4]);
    end
    check("walk_ovf", ch_ovf, 3'b001);
    exp_q[0] = model_mem[wa[4][4:0]];
    model_last = 0;
    check("walk_q", ch_q[7:0], exp_q[0]);

    // back-to-back on ch0: second toggle two cycles after completion is seen
    ack_delay = 5;
    req_we[0] = 1'b0; req_a[0] = 16'h0606;
    base = log_q.size();
    nd   = total_done();
    busy_gap = 0;
    pulse(3'b001);
    check("b2b_busy_post", ch_busy[0], 1);
    busy_watch = 1'b1;
    wait_log(base + 1, 40, "b2b_grant1");
    req_a[0] = 16'h070B;
    pulse(3'b001);
    wait_log(base + 2, 40, "b2b_grant2");
    busy_watch = 1'b0;
    wait_done(nd + 2, 60, "b2b_done");
    check("b2b_busy_gap", busy_gap, 0);
    if (log_q.size() >= base + 2 && ackc_q.size() > base)
      check("b2b_toggle_gap", log_q[base+1].cyc - ackc_q[base], 2);
    exp_q[0] = model_mem[5'h0B];
    @(negedge clk_sys);
    check("b2b_q", ch_q[7:0], exp_q[0]);

    // asynchronous reset while waiting for ack
    ack_delay = 20;
    req_we[1] = 1'b0; req_a[1] = 16'h0813;
    base = log_q.size();
    pulse(3'b010);
    wait_log(base + 1, 40, "ar_grant");
    nd = total_done();
    @(negedge clk_sys);
    #2 reset = 1'b1;
    #1;
    check("ar_mem_req", mem_req, 0);
    check("ar_mem_a", mem_a, 0);
    check("ar_mem_ctl", {mem_we, mem_ds}, 0);
    check("ar_mem_d", mem_d, 0);
    check("ar_ch_q", ch_q, 0);
    check("ar_flags", {ch_done, ch_busy, ch_ovf}, 0);
    @(negedge clk_sys);
    @(negedge clk_sys);
    reset = 1'b0;
    model_reset();
    repeat (25) @(negedge clk_sys);
    check("ar_no_done", total_done(), nd);
    req_we[2] = 1'b0; req_a[2] = 16'h0915;
    ack_delay = 3;
    base = log_q.size();
    pulse(3'b100);
    wait_log(base + 1, 40, "ar_regrant");
    check("ar_req_rise", mem_req, 1);
    wait_done(nd + 1, 40, "ar_done");
    exp_q[2] = model_mem[5'h15];
    @(negedge clk_sys);
    check("ar_q2", ch_q[23:16], exp_q[2]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
